// File: rtl/axi2spi.sv
// rtl/axi2spi.sv - AXI4-Lite slave to SPI master bridge, one 88-bit frame per access
module axi2spi #(
    parameter int CLK_DIV = 4
) (
    input  logic        axi_clk,
    input  logic        axi_rstn,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        spi_sck,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [3:0] {
        IDLE, SETUP, CMD, ADDR, WDATA, DUMM, RDATA, STAT, HOLD, GAP, RESP
    } state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nx;
    logic [8:0]  cnt;
    logic        sck_hi;
    logic [5:0]  bit_cnt;
    logic [71:0] tx_sh;
    logic [31:0] rx_data;
    logic [7:0]  stat;
    logic        is_read;
    logic        run;

    logic        wr_acc, rd_acc, bit_state, half_end, bit_end, seg_end, resp_done;
    logic [5:0]  seg_last;
    logic        unused_inputs;

    assign unused_inputs = ^{axi_awprot, axi_wstrb, axi_arprot};

    always_comb begin
        state_nx  = state;
        seg_last  = 6'd7;
        wr_acc    = (state == IDLE) && run && axi_awvalid && axi_wvalid;
        rd_acc    = (state == IDLE) && run && !(axi_awvalid && axi_wvalid) && axi_arvalid;
        bit_state = state inside {CMD, ADDR, WDATA, DUMM, RDATA, STAT};
        half_end  = (cnt == HALF_LAST);
        if (state inside {ADDR, WDATA, RDATA})
            seg_last = 6'd31;
        bit_end   = bit_state && sck_hi && half_end;
        seg_end   = bit_end && (bit_cnt == seg_last);
        resp_done = (state == RESP) && (is_read ? axi_rready : axi_bready);
        case (state)
            IDLE:    if (wr_acc || rd_acc) state_nx = SETUP;
            SETUP:   if (half_end) state_nx = CMD;
            CMD:     if (seg_end) state_nx = ADDR;
            ADDR:    if (seg_end) state_nx = is_read ? DUMM : WDATA;
            WDATA:   if (seg_end) state_nx = DUMM;
            DUMM:    if (seg_end) state_nx = is_read ? RDATA : STAT;
            RDATA:   if (seg_end) state_nx = STAT;
            STAT:    if (seg_end) state_nx = HOLD;
            HOLD:    if (half_end) state_nx = GAP;
            GAP:     if (cnt == GAP_LAST) state_nx = RESP;
            RESP:    if (resp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            sck_hi  <= 1'b0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_data <= '0;
            stat    <= '0;
            is_read <= 1'b0;
            run     <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nx;
            if (wr_acc || rd_acc) begin
                is_read <= rd_acc;
                tx_sh   <= wr_acc ? {8'h00, axi_awaddr, axi_wdata} : {8'h01, axi_araddr, 32'h0};
            end
            if (state == IDLE || state == RESP)
                cnt <= '0;
            else if ((state == GAP) ? (cnt == GAP_LAST) : half_end)
                cnt <= '0;
            else
                cnt <= cnt + 9'd1;
            if (bit_state && half_end)
                sck_hi <= !sck_hi;
            // One bit cell ends on the last high-phase cycle: sample MISO, advance MOSI.
            if (bit_end) begin
                tx_sh   <= {tx_sh[70:0], 1'b0};
                bit_cnt <= seg_end ? 6'd0 : bit_cnt + 6'd1;
                if (state == RDATA)
                    rx_data <= {rx_data[30:0], spi_miso};
                if (state == STAT)
                    stat <= {stat[6:0], spi_miso};
            end
        end
    end

    assign axi_awready = wr_acc;
    assign axi_wready  = wr_acc;
    assign axi_arready = rd_acc;
    assign axi_bvalid  = (state == RESP) && !is_read;
    assign axi_rvalid  = (state == RESP) && is_read;
    assign axi_bresp   = stat[1:0];
    assign axi_rresp   = stat[1:0];
    assign axi_rdata   = rx_data;
    assign spi_ss      = state inside {IDLE, GAP, RESP};
    assign spi_sck     = bit_state && sck_hi;
    assign spi_mosi    = (state inside {CMD, ADDR, WDATA}) && tx_sh[71];

endmodule

// File: tb/tb_axi2spi.sv
// tb/tb_axi2spi.sv - directed scoreboard bench for axi2spi at CLK_DIV 4 and 2
`timescale 1ns/1ps
module tb_axi2spi;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
        logic [1:0]  resp;
    } resp_t;

    logic        axi_clk = 1'b0;
    logic        axi_rstn;
    logic        awvalid, wvalid, arvalid, bready, rready, miso, sel;
    logic [31:0] awaddr, wdata, araddr;

    logic        awready4, wready4, arready4, bvalid4, rvalid4, sck4, ss4, mosi4;
    logic        awready2, wready2, arready2, bvalid2, rvalid2, sck2, ss2, mosi2;
    logic [1:0]  bresp4, rresp4, bresp2, rresp2;
    logic [31:0] rdata4, rdata2;

    logic        awready, wready, arready, bvalid, rvalid, sck_m, ss_m, mosi_m;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int          tests = 0;
    int          fails = 0;

    resp_t       exp_resp_q[$];
    logic [87:0] exp_frame_q[$];
    logic [87:0] obs_frame_q[$];
    int          obs_sck_q[$];

    logic [87:0] miso_frame = '0;
    logic [87:0] mosi_fr = '0;
    int          sck_cnt = 0;
    int          rx_idx = 0;
    int          first_rise = 0;
    int          second_rise = 0;
    int          sck_hi_errs = 0;
    logic        prev_ss = 1'b1;
    logic        prev_sck = 1'b0;

    always #5 axi_clk = ~axi_clk;

    axi2spi #(.CLK_DIV(4)) dut4 (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn),
        .axi_awvalid(awvalid & ~sel), .axi_awready(awready4), .axi_awaddr(awaddr), .axi_awprot(3'b000),
        .axi_wvalid(wvalid & ~sel), .axi_wready(wready4), .axi_wdata(wdata), .axi_wstrb(4'hF),
        .axi_bvalid(bvalid4), .axi_bready(bready), .axi_bresp(bresp4),
        .axi_arvalid(arvalid & ~sel), .axi_arready(arready4), .axi_araddr(araddr), .axi_arprot(3'b000),
        .axi_rvalid(rvalid4), .axi_rready(rready), .axi_rdata(rdata4), .axi_rresp(rresp4),
        .spi_sck(sck4), .spi_ss(ss4), .spi_mosi(mosi4), .spi_miso(miso)
    );

    axi2spi #(.CLK_DIV(2)) dut2 (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn),
        .axi_awvalid(awvalid & sel), .axi_awready(awready2), .axi_awaddr(awaddr), .axi_awprot(3'b000),
        .axi_wvalid(wvalid & sel), .axi_wready(wready2), .axi_wdata(wdata), .axi_wstrb(4'hF),
        .axi_bvalid(bvalid2), .axi_bready(bready), .axi_bresp(bresp2),
        .axi_arvalid(arvalid & sel), .axi_arready(arready2), .axi_araddr(araddr), .axi_arprot(3'b000),
        .axi_rvalid(rvalid2), .axi_rready(rready), .axi_rdata(rdata2), .axi_rresp(rresp2),
        .spi_sck(sck2), .spi_ss(ss2), .spi_mosi(mosi2), .spi_miso(miso)
    );

    assign awready = sel ? awready2 : awready4;
    assign wready  = sel ? wready2  : wready4;
    assign arready = sel ? arready2 : arready4;
    assign bvalid  = sel ? bvalid2  : bvalid4;
    assign rvalid  = sel ? rvalid2  : rvalid4;
    assign bresp   = sel ? bresp2   : bresp4;
    assign rresp   = sel ? rresp2   : rresp4;
    assign rdata   = sel ? rdata2   : rdata4;
    assign sck_m   = sel ? sck2     : sck4;
    assign ss_m    = sel ? ss2      : ss4;
    assign mosi_m  = sel ? mosi2    : mosi4;

    function automatic int cyc_now();
        return int'(($time - 5) / 10);
    endfunction

    // SPI slave model: captures MOSI on SCK rise, presents the next MISO bit after SCK fall.
    always @(ss_m or sck_m) begin
        if (ss_m !== prev_ss) begin
            if (!ss_m) begin
                sck_cnt = 0;
                mosi_fr = '0;
                rx_idx  = 0;
                miso    = miso_frame[87];
            end else begin
                obs_frame_q.push_back(mosi_fr);
                obs_sck_q.push_back(sck_cnt);
            end
        end
        if (sck_m !== prev_sck) begin
            if (sck_m) begin
                if (ss_m)
                    sck_hi_errs++;
                mosi_fr = {mosi_fr[86:0], mosi_m};
                sck_cnt++;
                if (sck_cnt == 1) first_rise = cyc_now();
                if (sck_cnt == 2) second_rise = cyc_now();
            end else begin
                rx_idx++;
                if (rx_idx < 88)
                    miso = miso_frame[87 - rx_idx];
            end
        end
        prev_ss  = ss_m;
        prev_sck = sck_m;
    end

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] st);
        resp_t e;
        e = '{rd: 1'b0, data: 32'h0, resp: st[1:0]};
        exp_frame_q.push_back({8'h00, a, d, 16'h0});
        exp_resp_q.push_back(e);
    endtask

    task automatic push_read(input logic [31:0] a, input logic [31:0] d, input logic [7:0] st);
        resp_t e;
        e = '{rd: 1'b1, data: d, resp: st[1:0]};
        exp_frame_q.push_back({8'h01, a, 48'h0});
        exp_resp_q.push_back(e);
    endtask

    task automatic accept(input logic wr, input logic keep_ar, output int t);
        int n;
        n = 0;
        awvalid = wr;
        wvalid  = wr;
        arvalid = !wr || keep_ar;
        #1;
        while (!(wr ? awready : arready) && n < 2000) begin
            @(negedge axi_clk); #1;
            n++;
        end
        t = cyc_now();
        if (wr) begin
            check("aw_accept", 88'(awready), 88'(1));
            check("w_ready_with_aw", 88'(wready), 88'(1));
            check("ar_blocked_by_write", 88'(arready), 88'(0));
        end else begin
            check("ar_accept", 88'(arready), 88'(1));
        end
        @(negedge axi_clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!keep_ar)
            arvalid = 1'b0;
        #1;
        check("ready_one_cycle", 88'(awready | wready | arready), 88'(0));
    endtask

    task automatic finish_resp(input int t, input int cd, input int hold);
        resp_t       e;
        int          n;
        logic        ok;
        logic [1:0]  r0;
        e = exp_resp_q.pop_front();
        n = 0;
        while (!(bvalid || rvalid) && n < 4000) begin
            @(negedge axi_clk); #1;
            n++;
        end
        check("resp_latency", 88'(cyc_now() - t), 88'(1 + 180 * cd));
        check("bvalid", 88'(bvalid), 88'(!e.rd));
        check("rvalid", 88'(rvalid), 88'(e.rd));
        if (e.rd) begin
            check("rresp", 88'(rresp), 88'(e.resp));
            check("rdata", 88'(rdata), 88'(e.data));
        end else begin
            check("bresp", 88'(bresp), 88'(e.resp));
        end
        if (hold > 0) begin
            ok = 1'b1;
            r0 = e.rd ? rresp : bresp;
            repeat (hold) begin
                @(negedge axi_clk); #1;
                if (!(bvalid == !e.rd && rvalid == e.rd && (e.rd ? rresp : bresp) == r0
                      && sck_m == 1'b0 && ss_m == 1'b1))
                    ok = 1'b0;
            end
            check("backpressure_stable", 88'(ok), 88'(1));
        end
        bready = 1'b1;
        rready = 1'b1;
        @(negedge axi_clk);
        bready = 1'b0;
        rready = 1'b0;
        #1;
        check("valid_cleared", 88'(bvalid | rvalid), 88'(0));
        check("frame_count", 88'(obs_frame_q.size()), 88'(1));
        if (obs_frame_q.size() > 0) begin
            check("mosi_frame", obs_frame_q.pop_front(), exp_frame_q.pop_front());
            check("sck_edges", 88'(obs_sck_q.pop_front()), 88'(88));
        end
        check("first_sck_rise", 88'(first_rise - t), 88'(1 + 2 * cd));
        check("bit_cell", 88'(second_rise - first_rise), 88'(2 * cd));
    endtask

    initial begin
        int   t;
        logic seen;
        sel = 1'b0;
        {awvalid, wvalid, arvalid, bready, rready} = '0;
        awaddr = '0; wdata = '0; araddr = '0;
        axi_rstn = 1'b1;
        #2 axi_rstn = 1'b0;
        repeat (3) @(negedge axi_clk);
        #1;
        check("rst_ss", 88'(ss_m), 88'(1));
        check("rst_sck", 88'(sck_m), 88'(0));
        check("rst_mosi", 88'(mosi_m), 88'(0));
        check("rst_readies", 88'({awready, wready, arready}), 88'(0));
        check("rst_valids", 88'({bvalid, rvalid}), 88'(0));
        check("rst_resp", 88'({bresp, rresp}), 88'(0));
        check("rst_rdata", 88'(rdata), 88'(0));
        obs_frame_q.delete();
        obs_sck_q.delete();
        @(negedge axi_clk);
        axi_rstn = 1'b1;
        repeat (2) @(negedge axi_clk);
        #1;

        awaddr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
        miso_frame = {80'h0, 8'h00};
        push_write(awaddr, wdata, 8'h00);
        accept(1'b1, 1'b0, t);
        finish_resp(t, 4, 0);

        araddr = 32'h0000_0020;
        miso_frame = {48'h0, 32'h1234_5678, 8'h02};
        push_read(araddr, 32'h1234_5678, 8'h02);
        accept(1'b0, 1'b0, t);
        finish_resp(t, 4, 0);

        // Write and read requested together: write frame first, read follows.
        awaddr = 32'h0000_0100; wdata = 32'hA5A5_0F0F; araddr = 32'h0000_0104;
        miso_frame = {80'h0, 8'h01};
        push_write(awaddr, wdata, 8'h01);
        push_read(araddr, 32'hCAFE_F00D, 8'h03);
        accept(1'b1, 1'b1, t);
        finish_resp(t, 4, 0);
        miso_frame = {48'h0, 32'hCAFE_F00D, 8'h03};
        accept(1'b0, 1'b0, t);
        finish_resp(t, 4, 0);

        awaddr = 32'h0000_0200; wdata = 32'h0123_4567;
        miso_frame = {80'h0, 8'hFD};
        push_write(awaddr, wdata, 8'hFD);
        accept(1'b1, 1'b0, t);
        finish_resp(t, 4, 50);
        araddr = 32'h0000_0204;
        miso_frame = {48'h0, 32'h89AB_CDEF, 8'hFF};
        push_read(araddr, 32'h89AB_CDEF, 8'hFF);
        accept(1'b0, 1'b0, t);
        finish_resp(t, 4, 0);

        // Reset in the middle of the ADDR field drops the transaction.
        awaddr = 32'h0000_0300; wdata = 32'h5555_AAAA;
        miso_frame = '0;
        accept(1'b1, 1'b0, t);
        while (cyc_now() < t + 100) begin
            @(negedge axi_clk); #1;
        end
        check("ss_low_mid_frame", 88'(ss_m), 88'(0));
        @(negedge axi_clk);
        axi_rstn = 1'b0;
        #1;
        check("abort_ss", 88'(ss_m), 88'(1));
        check("abort_sck", 88'(sck_m), 88'(0));
        check("abort_mosi", 88'(mosi_m), 88'(0));
        repeat (3) @(negedge axi_clk);
        axi_rstn = 1'b1;
        seen = 1'b0;
        repeat (800) begin
            @(negedge axi_clk); #1;
            if (bvalid || rvalid)
                seen = 1'b1;
        end
        check("no_resp_after_abort", 88'(seen), 88'(0));
        check("aborted_frame_only", 88'(obs_frame_q.size()), 88'(1));
        obs_frame_q.delete();
        obs_sck_q.delete();

        sel = 1'b1;
        araddr = 32'h0000_0030;
        miso_frame = {48'h0, 32'h5A5A_C3C3, 8'h01};
        push_read(araddr, 32'h5A5A_C3C3, 8'h01);
        @(negedge axi_clk); #1;
        accept(1'b0, 1'b0, t);
        finish_resp(t, 2, 0);

        check("sck_while_ss_high", 88'(sck_hi_errs), 88'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
